mux_nch_reg: RTL and testbench

MUX_NCH_REG -- requirements
Module: mux_nch_reg

---
 rtl/mux_nch_pkg.sv | 17 +
 rtl/rr_pick.sv | 32 +++
 rtl/mux_nch_reg.sv | 103 ++++++++++
 tb/tb_mux_nch_reg.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mux_nch_pkg.sv
// Shared constants and helpers for the N-channel registered mux.
// Mode encoding plus a constant-foldable clog2 used to size channel indices.
package mux_nch_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Wrapping first-set search: lowest requester at or above start, wrapping past CH-1 to 0.
// Latency: combinational. Backpressure: none, caller gates the grant.
// Outputs: one-hot grant, its binary index, and an any-grant flag.
module rr_pick #(
   parameter int CH = 4,
   parameter int SW = 2
) (
   input  logic [CH-1:0] req,
   input  logic [SW-1:0] start,
   output logic [CH-1:0] gnt,
   output logic [SW-1:0] idx,
   output logic          any
);

   always_comb begin
      int k;
      k   = 0;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int o = 0; o < CH; o++) begin
         k = int'(start) + o;
         if (k >= CH) k = k - CH;
         if (!any && req[k]) begin
            any    = 1'b1;
            gnt[k] = 1'b1;
            idx    = SW'(k);
         end
      end
   end

endmodule

// File: rtl/mux_nch_reg.sv
// CH-to-1 registered mux, fixed select or round-robin (round-robin only with MUX_NCH_RR_EN).
// Latency: 1 cycle from input transfer to out_valid; full throughput when out_ready stays high.
// Backpressure: while out_valid && !out_ready the word holds and every in_ready is low.
module mux_nch_reg
   import mux_nch_pkg::*;
#(
   parameter  int N  = 4,
   parameter  int CH = 4,
   localparam int SW = clog2(CH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [CH*N-1:0] in_data,
   input  logic [CH-1:0]   in_valid,
   output logic [CH-1:0]   in_ready,
   input  logic [SW-1:0]   sel,
   input  logic            mode,
   output logic [N-1:0]    out_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SW-1:0]   out_ch
);

   logic          load;
   logic          rr_en;
   logic          pick_any;
   logic [CH-1:0] sel_mask;
   logic [CH-1:0] pick_req;
   logic [CH-1:0] pick_gnt;
   logic [SW-1:0] pick_start;
   logic [SW-1:0] pick_idx;
   logic [N-1:0]  pick_word;

   assign load = !out_valid || out_ready;

   // Out-of-range sel matches no bit, so nothing is granted.
   always_comb begin
      sel_mask = '0;
      for (int k = 0; k < CH; k++) begin
         sel_mask[k] = (int'(sel) == k);
      end
   end

`ifdef MUX_NCH_RR_EN
   logic [SW-1:0] last;

   assign rr_en      = (mode == MODE_RR);
   assign pick_start = !rr_en ? '0 :
                       (last == SW'(CH-1)) ? '0 : last + SW'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last <= SW'(CH-1);
      end else if (load && pick_any && rr_en) begin
         last <= pick_idx;
      end
   end
`else
   logic unused_mode;

   assign unused_mode = mode;
   assign rr_en       = 1'b0;
   assign pick_start  = '0;
`endif

   // Fixed mode reuses the picker with the request masked down to sel.
   assign pick_req = rr_en ? in_valid : (in_valid & sel_mask);

   rr_pick #(
      .CH (CH),
      .SW (SW)
   ) u_pick (
      .req   (pick_req),
      .start (pick_start),
      .gnt   (pick_gnt),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   assign in_ready = (rst_n && load) ? pick_gnt : '0;

   always_comb begin
      pick_word = '0;
      for (int k = 0; k < CH; k++) begin
         if (pick_gnt[k]) pick_word = in_data[k*N +: N];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
      end else if (load) begin
         out_valid <= pick_any;
         if (pick_any) begin
            out_data <= pick_word;
            out_ch   <= pick_idx;
         end
      end
   end

endmodule

// File: tb/tb_mux_nch_reg.sv
// Directed bench for mux_nch_reg: expected words go into a queue, a negedge monitor checks output transfers.
module tb_mux_nch_reg;

   typedef struct packed {
      logic [3:0] d;
      logic [1:0] ch;
   } exp_t;

   logic clk;
   logic rst_n;

   logic [15:0] in_data4;
   logic [3:0]  in_valid4, in_ready4;
   logic [1:0]  sel4, out_ch4;
   logic        mode4, out_valid4, out_ready4;
   logic [3:0]  out_data4;

   logic [19:0] in_data5;
   logic [4:0]  in_valid5, in_ready5;
   logic [2:0]  sel5, out_ch5;
   logic        out_valid5;
   logic [3:0]  out_data5;

   logic [23:0] in_data6;
   logic [5:0]  in_valid6, in_ready6;
   logic [2:0]  sel6, out_ch6;
   logic        out_valid6;
   logic [3:0]  out_data6;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   mux_nch_reg #(.N(4), .CH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
      .sel(sel4), .mode(mode4), .out_data(out_data4), .out_valid(out_valid4),
      .out_ready(out_ready4), .out_ch(out_ch4));

   mux_nch_reg #(.N(4), .CH(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
      .sel(sel5), .mode(1'b0), .out_data(out_data5), .out_valid(out_valid5),
      .out_ready(1'b1), .out_ch(out_ch5));

   mux_nch_reg #(.N(4), .CH(6)) dut6 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data6), .in_valid(in_valid6), .in_ready(in_ready6),
      .sel(sel6), .mode(1'b0), .out_data(out_data6), .out_valid(out_valid6),
      .out_ready(1'b1), .out_ch(out_ch6));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every output transfer pops one expected word.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid4 === 1'b1 && out_ready4 === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_word: actual data=%0h ch=%0d required none", out_data4, out_ch4);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (out_data4 !== e.d || out_ch4 !== e.ch) begin
               n_bad++;
               $display("FAIL out_word: actual data=%0h ch=%0d required data=%0h ch=%0d",
                        out_data4, out_ch4, e.d, e.ch);
            end
         end
      end
   end

   logic [3:0] fix_words [4];
   logic [1:0] seq_ch [6];
   logic [3:0] rr_data [4];

   initial begin
      fix_words = '{4'hA, 4'hB, 4'hC, 4'hD};
      seq_ch    = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
      rr_data   = '{4'h1, 4'h2, 4'hF, 4'h4};

      rst_n      = 1'b0;
      in_data4   = 16'h0000;
      in_valid4  = 4'hF;
      sel4       = 2'd0;
      mode4      = 1'b0;
      out_ready4 = 1'b1;
      in_data5   = 20'hFFFFF;
      in_valid5  = 5'h1F;
      sel5       = 3'd5;
      in_data6   = 24'h9ABCDE;
      in_valid6  = 6'h3F;
      sel6       = 3'd5;

      for (int c = 0; c < 2; c++) begin
         step();
         chk("rst_out_valid", 32'(out_valid4), 32'd0);
         chk("rst_out_data", 32'(out_data4), 32'd0);
         chk("rst_out_ch", 32'(out_ch4), 32'd0);
         chk("rst_in_ready", 32'(in_ready4), 32'd0);
      end

      // Fixed select on channel 2, one word per cycle.
      rst_n     = 1'b1;
      in_data4  = {4'h3, 4'hA, 4'h5, 4'h7};
      in_valid4 = 4'b0100;
      sel4      = 2'd2;
      for (int i = 0; i < 4; i++) begin
         in_data4[11:8] = fix_words[i];
         #1;
         chk("fix_in_ready", 32'(in_ready4), 32'h4);
         exp_q.push_back('{d: fix_words[i], ch: 2'd2});
         step();
         chk("fix_out_valid", 32'(out_valid4), 32'd1);
      end

      // Hold D under backpressure, then replace with E with no bubble.
      out_ready4     = 1'b0;
      in_data4[11:8] = 4'hE;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("bp_in_ready", 32'(in_ready4), 32'd0);
         step();
         chk("bp_out_valid", 32'(out_valid4), 32'd1);
         chk("bp_out_data", 32'(out_data4), 32'hD);
         chk("bp_out_ch", 32'(out_ch4), 32'd2);
      end
      out_ready4 = 1'b1;
      #1;
      chk("bp_release_in_ready", 32'(in_ready4), 32'h4);
      exp_q.push_back('{d: 4'hE, ch: 2'd2});
      step();
      chk("no_bubble_valid", 32'(out_valid4), 32'd1);
      chk("no_bubble_data", 32'(out_data4), 32'hE);
      in_valid4 = 4'b0000;
      step();
      chk("drain_out_valid", 32'(out_valid4), 32'd0);

      in_data4 = {rr_data[3], rr_data[2], rr_data[1], rr_data[0]};
      mode4    = 1'b1;
`ifdef MUX_NCH_RR_EN
      in_valid4 = 4'b1011;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("rr_in_ready", 32'(in_ready4), 32'(4'b0001 << seq_ch[i]));
         exp_q.push_back('{d: rr_data[seq_ch[i]], ch: seq_ch[i]});
         step();
      end
`else
      sel4      = 2'd1;
      in_valid4 = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("norr_in_ready", 32'(in_ready4), 32'h2);
         exp_q.push_back('{d: 4'h2, ch: 2'd1});
         step();
      end
`endif
      in_valid4 = 4'b0000;
      step();
      chk("end_out_valid", 32'(out_valid4), 32'd0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      // sel=5: out of range for CH=5, valid channel for CH=6.
      chk("ch5_in_ready", 32'(in_ready5), 32'd0);
      chk("ch6_in_ready", 32'(in_ready6), 32'h20);
      step();
      chk("ch5_out_valid", 32'(out_valid5), 32'd0);
      chk("ch6_out_valid", 32'(out_valid6), 32'd1);
      chk("ch6_out_data", 32'(out_data6), 32'h9);
      chk("ch6_out_ch", 32'(out_ch6), 32'd5);
      step();
      chk("ch5_out_valid_2", 32'(out_valid5), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
